// File: rtl/four_bit_adder.sv
// four_bit_adder
//   Registered 4-bit unsigned adder with carry-in. The datapath is a
//   ripple-carry chain of four full-adder cells; the 5-bit result (carry-out
//   in s[4]) is captured one cycle after an accepted operation.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (wins over in_valid)
//   in_valid   a/b/cin are valid this cycle and are accepted at the edge
//   a, b       4-bit unsigned operands
//   cin        carry-in into bit 0
//   s          registered sum {carry_out, sum[3:0]}; holds between operations
//   out_valid  one-cycle pulse per accepted operation, qualifies s
//   ovf        registered two's-complement overflow flag
//              (present only when FOUR_BIT_ADDER_OVF_EN is defined)
//
// Build option
//   FOUR_BIT_ADDER_OVF_EN  adds the ovf port and its register.

module four_bit_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] s,
`ifdef FOUR_BIT_ADDER_OVF_EN
  output logic       out_valid,
  output logic       ovf
`else
  output logic       out_valid
`endif
);

  logic [3:0] sum_bits;
  logic       carry_out;

  // Ripple chain: the carry is a procedure-local variable so each cell's
  // carry-in is the previous cell's carry-out within one evaluation.
  always_comb begin : ripple_chain
    logic carry;
    carry    = cin;
    sum_bits = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      sum_bits[i] = a[i] ^ b[i] ^ carry;
      carry       = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    carry_out = carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= 5'b00000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= {carry_out, sum_bits};
      end
    end
  end

`ifdef FOUR_BIT_ADDER_OVF_EN
  // Signed overflow: operands agree in sign but the 4-bit result does not.
  logic ovf_next;
  assign ovf_next = (a[3] == b[3]) && (sum_bits[3] != a[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
module tb_four_bit_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [4:0] s;
  logic       out_valid;
`ifdef FOUR_BIT_ADDER_OVF_EN
  logic       ovf;
`endif

  four_bit_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .s         (s),
`ifdef FOUR_BIT_ADDER_OVF_EN
    .out_valid (out_valid),
    .ovf       (ovf)
`else
    .out_valid (out_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: plain integer arithmetic on the accepted operands.
  int exp_s       = 0;
  bit exp_v       = 1'b0;
  bit exp_ovf     = 1'b0;
  bit model_ready = 1'b0;

  always @(posedge clk) begin
    int sa, sb, ssum;
    if (rst) begin
      exp_s       = 0;
      exp_v       = 1'b0;
      exp_ovf     = 1'b0;
      model_ready = 1'b1;
    end else begin
      exp_v = in_valid;
      if (in_valid) begin
        exp_s   = int'(a) + int'(b) + int'(cin);
        sa      = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb      = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        ssum    = sa + sb + int'(cin);
        exp_ovf = (ssum > 7) || (ssum < -8);
      end
    end
  end

  // Every-cycle comparison against the model once reset has been seen.
  always @(negedge clk) begin
    if (model_ready) begin
      n_total++;
      if (int'(s) == exp_s) n_pass++;
      else $display("FAIL model_s t=%0t got=%0d want=%0d", $time, s, exp_s);
      n_total++;
      if (out_valid == exp_v) n_pass++;
      else $display("FAIL model_out_valid t=%0t got=%0b want=%0b", $time, out_valid, exp_v);
`ifdef FOUR_BIT_ADDER_OVF_EN
      n_total++;
      if (ovf == exp_ovf) n_pass++;
      else $display("FAIL model_ovf t=%0t got=%0b want=%0b", $time, ovf, exp_ovf);
`endif
    end
  end

  // Apply one cycle of stimulus from a negedge; return at the following
  // negedge with that cycle's result visible.
  task automatic step(input bit r, input bit v, input int av, input int bv, input bit c);
    rst      = r;
    in_valid = v;
    a        = av[3:0];
    b        = bv[3:0];
    cin      = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    @(negedge clk);

    // Reset, with an operation presented that must be discarded.
    step(1, 1, 5, 6, 0);
    step(1, 0, 0, 0, 0);
    lit("reset_s", int'(s), 0);
    lit("reset_out_valid", int'(out_valid), 0);

    step(0, 1, 0, 0, 0);
    lit("zero_s", int'(s), 0);
    lit("zero_out_valid", int'(out_valid), 1);

    // Back-to-back operations.
    step(0, 1, 0, 1, 0);   lit("b2b0_s", int'(s), 5'b00001); lit("b2b0_v", int'(out_valid), 1);
    step(0, 1, 0, 15, 0);  lit("b2b1_s", int'(s), 5'b01111); lit("b2b1_v", int'(out_valid), 1);
    step(0, 1, 15, 15, 0); lit("b2b2_s", int'(s), 5'b11110); lit("b2b2_v", int'(out_valid), 1);
    step(0, 1, 1, 15, 0);  lit("b2b3_s", int'(s), 5'b10000); lit("b2b3_v", int'(out_valid), 1);

    // Carry-in cases, including the maximum.
    step(0, 1, 15, 15, 1); lit("max_s", int'(s), 5'b11111);
    step(0, 1, 7, 8, 1);   lit("cin_7_8_s", int'(s), 5'b10000);

    // Hold while idle, operand changes ignored.
    step(0, 1, 3, 4, 0);   lit("hold_accept_s", int'(s), 5'b00111);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 15, 15, 1);
      lit("hold_s", int'(s), 5'b00111);
      lit("hold_out_valid", int'(out_valid), 0);
    end

    // Reset wins over in_valid.
    step(1, 1, 9, 9, 0);
    lit("rst_prio_s", int'(s), 0);
    lit("rst_prio_out_valid", int'(out_valid), 0);
    step(0, 0, 9, 9, 0);
    lit("rst_lost_out_valid", int'(out_valid), 0);
    lit("rst_lost_s", int'(s), 0);

    // Signed-overflow vectors (sum also checked in every build).
    step(0, 1, 7, 1, 0);
    lit("ovf_7_1_s", int'(s), 8);
`ifdef FOUR_BIT_ADDER_OVF_EN
    lit("ovf_7_1", int'(ovf), 1);
`endif
    step(0, 1, 8, 8, 0);
    lit("ovf_8_8_s", int'(s), 5'b10000);
`ifdef FOUR_BIT_ADDER_OVF_EN
    lit("ovf_8_8", int'(ovf), 1);
`endif
    step(0, 0, 0, 0, 0);
`ifdef FOUR_BIT_ADDER_OVF_EN
    lit("ovf_hold", int'(ovf), 1);
`endif
    step(0, 1, 15, 1, 0);
    lit("ovf_15_1_s", int'(s), 5'b10000);
`ifdef FOUR_BIT_ADDER_OVF_EN
    lit("ovf_15_1", int'(ovf), 0);
`endif

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 60; i++) begin
      step((i == 30), bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/four_bit_adder.md
FOUR_BIT_ADDER -- requirements
Module: four_bit_adder

Interface
Parameters:
REQ-001 None; operand width SHALL be fixed at 4 bits and sum width at 5 bits.
Ports:
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  high = a/b/cin valid this cycle.
REQ-005 a  input  4  unsigned operand A.
REQ-006 b  input  4  unsigned operand B.
REQ-007 cin  input  1  carry-in, added to a+b; tie low for plain A+B.
REQ-008 s  output  5  registered sum; s[4] = carry-out, s[3:0] = sum bits.
REQ-009 out_valid  output  1  high for one cycle per accepted operation; qualifies s.
REQ-010 ovf  output  1  registered two's-complement overflow flag; exists only when FOUR_BIT_ADDER_OVF_EN is defined (see Configuration).

Function
REQ-011 Datapath SHALL be a 4-stage ripple-carry chain of full-adder cells: sum_i = a_i ^ b_i ^ c_i, c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i, with c_0 = cin.
REQ-012 Result SHALL be full precision: s = a + b + cin as unsigned 5-bit, range 0..31, with no truncation or saturation.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled at edge N when in_valid=1 appear on s with out_valid=1 after edge N.
REQ-014 Throughput SHALL be one operation per cycle; back-to-back in_valid SHALL produce back-to-back results.
REQ-015 When in_valid=0 at an edge: s (and ovf) SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 No backpressure; results not consumed in their out_valid cycle remain readable on s until the next accepted operation or reset.
REQ-017 Operand changes while in_valid=0 SHALL not affect s.
REQ-018 Boundary: 15+15+1 = 31 (s=5'b11111) SHALL be the maximum; 0+0+0 SHALL give s=0.
REQ-019 No combinational path SHALL exist from any input to any output.

Reset
REQ-020 rst=1 at a rising edge SHALL force s=5'b00000, out_valid=0, ovf=0 regardless of in_valid.
REQ-021 rst SHALL take priority over in_valid; an operation presented in a reset cycle SHALL be discarded and produce no out_valid.
REQ-022 Before the first rising edge with rst=1, output values are undefined; the bench SHALL apply reset first.

Configuration
REQ-023 Macro FOUR_BIT_ADDER_OVF_EN: when defined, port ovf SHALL exist and be registered alongside s, set to (a[3]==b[3]) && (sum[3]!=a[3]) for the accepted operation, with cin included in sum.
REQ-024 When FOUR_BIT_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then a=0000 b=0000 cin=0 in_valid=1 -> next cycle s=00000, out_valid=1.
REQ-026 Sequence a/b = 0/1, 0/15, 15/15, 1/15, cin=0, back-to-back in_valid=1 -> s = 00001, 01111, 11110, 10000 on consecutive cycles, out_valid high throughout.
REQ-027 a=15 b=15 cin=1 -> s=11111; a=7 b=8 cin=1 -> s=10000.
REQ-028 Accept a=3 b=4 (s=00111), then in_valid=0 with a=15 b=15 for 3 cycles -> s stays 00111, out_valid=0.
REQ-029 in_valid=1 a=9 b=9 with rst=1 in the same cycle -> s=00000, out_valid=0; the operation is lost.
REQ-030 With FOUR_BIT_ADDER_OVF_EN defined: a=0111 b=0001 -> ovf=1; a=1000 b=1000 -> ovf=1 with s=10000; a=1111 b=0001 -> ovf=0.
